// File: rtl/four_bit_serial_subtractor_if.sv
// Request/response bundle for the bit-serial 4-bit subtractor.
// Both directions use the same valid/ready rule: a transfer happens on the
// rising clk edge where valid and ready are both high; the sender holds its
// payload stable while valid is high and ready is low.
interface four_bit_serial_subtractor_if;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
    logic       done_valid;
    logic       done_ready;

    modport master (
        output start_valid, a, b, bin, done_ready,
        input  start_ready, diff, bout, ovf, done_valid
    );

    modport slave (
        input  start_valid, a, b, bin, done_ready,
        output start_ready, diff, bout, ovf, done_valid
    );
endinterface

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial 4-bit subtractor: diff = a - b - bin, one bit per clock, LSB
// first, with the ripple borrow kept in a register.
// Optional feature macro: SUB_SIGNED_OVF_EN (registered two's-complement
// overflow flag on ovf; when undefined ovf is tied low).
// Outputs come only from registers or the state register, so there is no
// combinational path from any input to any output.
module four_bit_serial_subtractor (
    input  logic                          clk,
    input  logic                          rst,
    four_bit_serial_subtractor_if.slave   bus,
    output logic [1:0]                    state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] a_sh;
    logic [3:0] b_sh;
    logic       br;
    logic [1:0] cnt;
    logic [3:0] diff_r;
    logic       bout_r;
    logic       d_bit;
    logic       br_next;

`ifdef SUB_SIGNED_OVF_EN
    logic       br3;
    logic       ovf_r;
`endif

    // One full-subtractor cell applied to the current LSBs of the operands.
    assign d_bit   = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

    assign bus.start_ready = (state == IDLE);
    assign bus.done_valid  = (state == DONE);
    assign bus.diff        = diff_r;
    assign bus.bout        = bout_r;
    assign state_dbg       = state;

`ifdef SUB_SIGNED_OVF_EN
    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif

    // Control FSM plus datapath shift registers, advanced one bit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= 4'd0;
            b_sh   <= 4'd0;
            br     <= 1'b0;
            cnt    <= 2'd0;
            diff_r <= 4'd0;
            bout_r <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            br3    <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        br    <= bus.bin;
                        cnt   <= 2'd0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // New bit enters at the MSB so bit 0 ends at diff[0].
                    diff_r <= {d_bit, diff_r[3:1]};
                    a_sh   <= {1'b0, a_sh[3:1]};
                    b_sh   <= {1'b0, b_sh[3:1]};
                    br     <= br_next;
                    cnt    <= cnt + 2'd1;
`ifdef SUB_SIGNED_OVF_EN
                    // Borrow leaving bit 2 is the borrow into the sign bit.
                    if (cnt == 2'd2) begin
                        br3 <= br_next;
                    end
`endif
                    if (cnt == 2'd3) begin
                        bout_r <= br_next;
`ifdef SUB_SIGNED_OVF_EN
                        // Overflow when borrow into and out of the sign bit differ.
                        ovf_r  <= br3 ^ br_next;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Self-checking bench for four_bit_serial_subtractor. Expected results are
// queued at the accept edge; a monitor pops and compares on every result
// handshake. Honors SUB_SIGNED_OVF_EN for the expected ovf value.
module tb_four_bit_serial_subtractor;

`ifdef SUB_SIGNED_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_q[$];
    bit         rand_done = 1'b0;

    four_bit_serial_subtractor_if bus ();

    four_bit_serial_subtractor dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: unsigned wrap and borrow, plus signed range test for overflow.
    function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mbin);
        logic [4:0] full;
        int         sa;
        int         sb;
        int         sr;
        logic       o;
        full = {1'b0, ma} - {1'b0, mb} - {4'b0, mbin};
        sa   = ma[3] ? int'(ma) - 16 : int'(ma);
        sb   = mb[3] ? int'(mb) - 16 : int'(mb);
        sr   = sa - sb - int'(mbin);
        o    = OVF_EN && (sr < -8 || sr > 7);
        return {full[3:0], full[4], o};
    endfunction

    // Issue one operation; called at posedge+1, returns at accept edge+1.
    task automatic send(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin, input logic [5:0] e);
        logic rdy;
        bit   ok;
        ok              = 1'b0;
        bus.a           = ta;
        bus.b           = tb_v;
        bus.bin         = tbin;
        bus.start_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rdy = bus.start_ready && !rst;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        #1;
        bus.start_valid = 1'b0;
    endtask

    // Wait until every queued result has been consumed.
    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: compare on each result handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus.done_valid === 1'b1 && bus.done_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none",
                         {bus.diff, bus.bout, bus.ovf});
            end else begin
                check("result", {bus.diff, bus.bout, bus.ovf}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int lat;
        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.a           = 4'd0;
        bus.b           = 4'd0;
        bus.bin         = 1'b0;
        bus.done_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_diff", bus.diff, 4'h0);
        check("rst_bout", bus.bout, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_done_valid", bus.done_valid, 1'b0);
        check("rst_start_ready", bus.start_ready, 1'b1);

        // Basic unsigned, with latency measurement.
        send(4'd9, 4'd3, 1'b0, {4'h6, 1'b0, 1'b0});
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 4);
        drain(50);

        // Borrow and signed overflow; borrow-in chain.
        send(4'd3, 4'd9, 1'b0, {4'hA, 1'b1, OVF_EN});
        drain(50);
        send(4'd0, 4'd0, 1'b1, {4'hF, 1'b1, 1'b0});
        drain(50);
        send(4'd8, 4'd1, 1'b0, {4'h7, 1'b0, OVF_EN});
        drain(50);

        // Backpressure: result must hold while inputs wiggle.
        bus.done_ready = 1'b0;
        send(4'd9, 4'd3, 1'b0, {4'h6, 1'b0, 1'b0});
        for (int k = 0; k < 20; k++) begin
            if (bus.done_valid) break;
            @(posedge clk);
            #1;
        end
        check("bp_valid_rise", bus.done_valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            bus.a           = 4'($urandom_range(0, 15));
            bus.b           = 4'($urandom_range(0, 15));
            bus.start_valid = ~bus.start_valid;
            @(posedge clk);
            #1;
            check("bp_hold", {bus.diff, bus.bout, bus.ovf}, {4'h6, 1'b0, 1'b0});
            check("bp_start_ready", bus.start_ready, 1'b0);
            check("bp_done_valid", bus.done_valid, 1'b1);
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", bus.start_ready, 1'b1);
        check("bp_release_valid", bus.done_valid, 1'b0);
        drain(20);

        // Reset in the middle of a 9-3 operation, seen at E2.
        send(4'd9, 4'd3, 1'b0, {4'h6, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_done_valid", bus.done_valid, 1'b0);
        check("mid_rst_diff", bus.diff, 4'h0);
        check("mid_rst_bout", bus.bout, 1'b0);
        check("mid_rst_ovf", bus.ovf, 1'b0);
        check("mid_rst_start_ready", bus.start_ready, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        send(4'd5, 4'd5, 1'b0, {4'h0, 1'b0, 1'b0});
        drain(50);

        // Back-to-back random operations with random stalls on both sides.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [3:0] ra;
                    logic [3:0] rb;
                    logic       rbin;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    ra   = 4'($urandom_range(0, 15));
                    rb   = 4'($urandom_range(0, 15));
                    rbin = 1'($urandom_range(0, 1));
                    send(ra, rb, rbin, model(ra, rb, rbin));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.done_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.done_ready = 1'b1;
        drain(200);
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_serial_subtractor.md
# four_bit_serial_subtractor

Bit-serial 4-bit binary subtractor computing `diff = a - b - bin` one bit per clock, LSB first, with a ripple borrow held in a register. It is the inverse-operation counterpart of the team's combinational 4-bit ripple adder. It targets area-constrained paths where a few cycles of latency are acceptable. Operands enter through a valid/ready request handshake; results leave through a valid/ready response handshake and are held until consumed.

## Interface

Parameters:
- none (width fixed at 4 bits)

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start_valid` input 1: operands valid.
- `start_ready` output 1: block can accept operands.
- `a` input 4: minuend, unsigned or two's complement.
- `b` input 4: subtrahend.
- `bin` input 1: borrow-in.
- `diff` output 4: registered difference.
- `bout` output 1: registered borrow-out; 1 when `a < b + bin` unsigned.
- `ovf` output 1: signed overflow flag (see Configuration).
- `done_valid` output 1: result valid.
- `done_ready` input 1: consumer accepts result.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- `start_ready = (state == IDLE)`. `done_valid = (state == DONE)`.
- IDLE:
  - On `start_valid && start_ready`, capture `a`, `b` and `bin` into shift/borrow registers.
  - Clear the bit counter and go to SHIFT.
- SHIFT (exactly 4 cycles, bit i = 0..3):
  - `d_i = a_i ^ b_i ^ br`.
  - `br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)`.
  - Shift `d_i` into `diff` from the MSB side so bit 0 lands at `diff[0]` after 4 shifts.
  - Before processing bit 3, latch the borrow into bit 3 (`br3`).
  - After bit 3: `bout = br_next`, then go to DONE.
- DONE:
  - `diff`, `bout` and `ovf` are held stable.
  - On `done_valid && done_ready`, go to IDLE.
- Operand inputs are sampled only at the accept edge. Changes during SHIFT or DONE are ignored.
- `start_valid` is ignored outside IDLE. No operand is queued.
- Intermediate `diff` bits during SHIFT are don't-care. Consumers read only while `done_valid` is high.
- Reset (any state, including mid-SHIFT or DONE):
  - Operation aborted with no result delivered.
  - State returns to IDLE.
  - `diff = 0`, `bout = 0`, `ovf = 0`, `done_valid = 0`, `start_ready = 1` from the cycle after the reset edge.
- While `rst` is high, handshakes are ignored.

## Timing

- Accept edge is E0. SHIFT occupies edges E1–E4. `done_valid` rises after E4, i.e. 4 cycles after acceptance.
- The result is held indefinitely while `done_ready` is low.
- The DONE→IDLE transition takes effect at the handshake edge. `start_ready` is high in the following cycle.
- A new accept is never in the same cycle as result consumption. Peak throughput is one operation per 6 cycles.
- All outputs are registered or decoded directly from the state register. There is no combinational input→output path.

## Configuration

- Macro `SUB_SIGNED_OVF_EN`:
  - Defined: `ovf` is registered at the end of SHIFT as `br3 ^ bout`, i.e. two's-complement overflow of `a - b - bin`. It is held in DONE and cleared on reset.
  - Undefined: `ovf` is tied to 0 and the `br3` register is removed. The port stays present, so the interface is identical in both builds.

## Test plan

- **Basic unsigned:** a=9, b=3, bin=0 → diff=6, bout=0, ovf=0. `done_valid` rises exactly 4 cycles after accept.
- **Borrow and signed overflow:** a=3, b=9, bin=0 → diff=0xA, bout=1. ovf=1 with the macro, 0 without.
- **Borrow-in chain:** a=0, b=0, bin=1 → diff=0xF, bout=1, ovf=0. Also a=8, b=1, bin=0 → diff=0x7, bout=0, ovf=1 with the macro.
- **Backpressure:** hold `done_ready`=0 for 3 cycles after `done_valid` rises, and toggle a/b/start_valid during that time. Required response:
  - diff/bout/ovf stay stable.
  - `start_ready` stays 0 and no second accept occurs.
  - After the handshake, `start_ready`=1 on the next cycle.
- **Reset mid-operation:** assert `rst` for 1 cycle at E2 of a 9−3 operation. Required response:
  - The next cycle shows done_valid=0, diff=0, bout=0, start_ready=1.
  - No stale result ever appears.
  - A following 5−5 operation yields diff=0, bout=0.
- **Back-to-back:** random 200 operations with random valid/ready stalls, checked against a reference model of `(a - b - bin) mod 16` and its borrow.
